// File: rtl/reload_down_timer.sv
// Reloadable down-counting timer with one-shot and periodic auto-reload modes.
// Raises a one-cycle terminal-count pulse each time the count expires from 1.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | not counting; data_o holds a loaded or stopped count
//   RUN     | counting down one per clock
//   DONE    | one-shot expired; data_o is 0, start re-arms from rld
module reload_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] data_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] rld_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             count_zero;
    logic             count_one;
    logic             rld_zero;

    assign count_zero = (data_o == '0);
    assign count_one  = (data_o == WIDTH'(1));
    assign rld_zero   = (rld == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority: load, then stop, then start, then counting.
    always_comb begin
        state_nxt = state;
        if (load_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !count_zero) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state_nxt = ST_IDLE;
                    end else if (count_one && !mode_i) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start_i && !rld_zero) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rld_nxt   = rld;
        count_nxt = data_o;
        tc_nxt    = 1'b0;
        if (load_i) begin
            rld_nxt   = data_i;
            count_nxt = data_i;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stop_i) begin
                        if (count_one) begin
                            tc_nxt    = 1'b1;
                            count_nxt = mode_i ? rld : '0;
                        end else if (!count_zero) begin
                            count_nxt = data_o - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (start_i) begin
                        count_nxt = rld;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rld    <= '0;
            data_o <= '0;
            tc_o   <= 1'b0;
        end else begin
            rld    <= rld_nxt;
            data_o <= count_nxt;
            tc_o   <= tc_nxt;
        end
    end

    // Status flags come from the state register alone so they never glitch on inputs.
    always_comb begin
        busy_o = (state == ST_RUN);
        done_o = (state == ST_DONE);
    end

endmodule

// File: tb/tb_reload_down_timer.sv
// Bench for reload_down_timer: directed scenarios plus a randomized run,
// all checked against a rule-level reference model.
module tb_reload_down_timer;

    localparam int W = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_i;
    logic [W-1:0] data_i;
    logic         start_i;
    logic         stop_i;
    logic         mode_i;
    logic [W-1:0] data_o;
    logic         tc_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    int m_st;
    int m_rld;
    int m_cnt;
    int m_tc;

    reload_down_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_i),
        .data_i  (data_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .mode_i  (mode_i),
        .data_o  (data_o),
        .tc_o    (tc_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_st  = M_IDLE;
        m_rld = 0;
        m_cnt = 0;
        m_tc  = 0;
    endfunction

    // One clock edge of behaviour, straight from the priority rules.
    function automatic void model_edge();
        m_tc = 0;
        if (load_i) begin
            m_rld = int'(data_i);
            m_cnt = int'(data_i);
            m_st  = M_IDLE;
        end else if (stop_i && m_st == M_RUN) begin
            m_st = M_IDLE;
        end else if (start_i && m_st == M_IDLE) begin
            if (m_cnt != 0) m_st = M_RUN;
        end else if (start_i && m_st == M_DONE) begin
            m_cnt = m_rld;
            if (m_rld != 0) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_tc = 1;
                if (mode_i) begin
                    m_cnt = m_rld;
                end else begin
                    m_cnt = 0;
                    m_st  = M_DONE;
                end
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".data"}, 32'(data_o), 32'(m_cnt));
        check({tag, ".tc"},   32'(tc_o),   32'(m_tc));
        check({tag, ".busy"}, 32'(busy_o), 32'(m_st == M_RUN));
        check({tag, ".done"}, 32'(done_o), 32'(m_st == M_DONE));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic do_load(input int v);
        load_i = 1'b1;
        data_i = W'(v);
        tick("load");
        load_i = 1'b0;
    endtask

    task automatic do_start(input logic m);
        mode_i  = m;
        start_i = 1'b1;
        tick("start");
        start_i = 1'b0;
    endtask

    initial begin
        int tc_seen;
        rst = 1'b1; load_i = 0; data_i = '0; start_i = 0; stop_i = 0; mode_i = 0;
        model_reset();
        #12;
        check("reset.data", 32'(data_o), 0);
        check("reset.tc",   32'(tc_o),   0);
        check("reset.busy", 32'(busy_o), 0);
        check("reset.done", 32'(done_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // start with count 0 after reset is ignored
        do_start(1'b0);
        check("start_zero.busy", 32'(busy_o), 0);

        // one-shot 5
        do_load(5);
        do_start(1'b0);
        check("os5.first", 32'(data_o), 5);
        for (int k = 1; k <= 5; k++) begin
            tick("os5");
            check("os5.seq", 32'(data_o), 32'(5 - k));
            check("os5.tc",  32'(tc_o),   32'(k == 5));
        end
        check("os5.done", 32'(done_o), 1);
        check("os5.busy", 32'(busy_o), 0);

        // periodic 3
        do_load(3);
        do_start(1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick("per3");
            check("per3.seq",  32'(data_o), 32'(3 - (k % 3)));
            check("per3.tc",   32'(tc_o),   32'(k % 3 == 0));
            check("per3.busy", 32'(busy_o), 1);
        end

        // stop at 150 then resume
        do_load(200);
        do_start(1'b0);
        for (int k = 0; k < 50; k++) tick("run200");
        check("stop.pre", 32'(data_o), 150);
        stop_i = 1'b1;
        tick("stop");
        stop_i = 1'b0;
        check("stop.hold", 32'(data_o), 150);
        check("stop.idle", 32'(busy_o), 0);
        do_start(1'b0);
        tick("resume");
        check("resume.149", 32'(data_o), 149);

        // load aborts run
        do_load(4);
        do_start(1'b0);
        tick("r4"); tick("r4");
        check("abort.pre", 32'(data_o), 2);
        do_load(9);
        check("abort.data", 32'(data_o), 9);
        check("abort.busy", 32'(busy_o), 0);
        check("abort.tc",   32'(tc_o),   0);
        do_start(1'b0);
        tc_seen = 0;
        for (int k = 1; k <= 9; k++) begin
            tick("r9");
            if (tc_o) tc_seen = k;
        end
        check("r9.latency", 32'(tc_seen), 9);

        // DONE restart, then load 0
        do_load(2);
        do_start(1'b0);
        tick("r2"); tick("r2");
        check("r2.done", 32'(done_o), 1);
        do_start(1'b0);
        check("redo.data", 32'(data_o), 2);
        check("redo.busy", 32'(busy_o), 1);
        tick("redo"); tick("redo");
        check("redo.tc", 32'(tc_o), 1);
        do_load(0);
        do_start(1'b0);
        check("zero.busy", 32'(busy_o), 0);
        check("zero.data", 32'(data_o), 0);

        // periodic reload of 1 pulses every cycle
        do_load(1);
        do_start(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick("per1");
            check("per1.tc", 32'(tc_o), 1);
        end

        // async reset mid-run
        do_load(10);
        do_start(1'b0);
        tick("r10"); tick("r10"); tick("r10");
        check("ar.pre", 32'(data_o), 7);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_model("async_rst");
        #1 rst = 1'b0;
        do_start(1'b0);
        check("ar.ignored", 32'(busy_o), 0);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            load_i  = ($urandom_range(99) < 5);
            stop_i  = ($urandom_range(99) < 5);
            start_i = ($urandom_range(99) < 15);
            if ($urandom_range(99) < 10) mode_i = 1'($urandom);
            data_i  = ($urandom_range(9) == 0) ? W'($urandom) : W'($urandom_range(6));
            tick("rand");
        end
        load_i = 0; stop_i = 0; start_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
